// File: rtl/neural_acq_pkg.sv
// Shared types and constants for the neural acquisition framer.
package neural_acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RAW  = 2'd0;
    localparam logic [1:0] MODE_DEC2 = 2'd1;
    localparam logic [1:0] MODE_DEC4 = 2'd2;
    localparam logic [1:0] MODE_THR  = 2'd3;

    // Header channel tag; callers slice the low CH_W bits.
    localparam logic [31:0] HDR_TAG = 32'hFFFF_FFFF;

    function automatic int word_w(input int ch_w, input int ts_w, input int sample_w);
        return ch_w + ts_w + sample_w;
    endfunction

endpackage

// File: rtl/neural_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
module neural_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Fullness is judged on the registered level, so a same-cycle pop cannot free a slot.
    assign full    = (level == FULL_LVL);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && (level != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/neural_acq_framer.sv
// Acquisition framer: channel filter, timestamping, FIFO buffering and
// header/payload/checksum framing onto a valid/ready stream.
module neural_acq_framer
    import neural_acq_pkg::*;
#(
    parameter int SAMPLE_W  = 12,
    parameter int TS_W      = 16,
    parameter int CH_W      = 4,
    parameter int N_CH      = 16,
    parameter int DEPTH     = 32,
    parameter int FRAME_LEN = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          in_valid,
    input  logic [SAMPLE_W-1:0]           in_sample,
    input  logic [CH_W-1:0]               in_channel,
    input  logic [N_CH-1:0]               ch_enable,
    input  logic [1:0]                    mode,
    input  logic [SAMPLE_W-1:0]           threshold,
    input  logic                          flush_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_W+TS_W+SAMPLE_W-1:0] out_data,
    output logic                          out_sof,
    output logic                          out_eof,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic [15:0]                   drop_count
);

    localparam int W     = word_w(CH_W, TS_W, SAMPLE_W);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]  ts;
    logic [1:0]       phase [N_CH];
    logic [1:0]       mode_q;
    logic             ch_ok;
    logic             keep;
    logic             fifo_full;
    logic             pop;
    logic [W-1:0]     fifo_head;

    state_t           state, state_d;
    logic [LVL_W-1:0] cnt, cnt_d, pay_cnt;
    logic [W-1:0]     chk;
    logic [TS_W-1:0]  frame_seq;
    logic             flush_pend;
    logic             start;
    logic             hs;

    // ---- input filter stage ----
    always_comb begin
        keep  = 1'b0;
        ch_ok = in_valid && (int'(in_channel) < N_CH) && ch_enable[in_channel];
        case (mode)
            MODE_RAW:            keep = ch_ok;
            MODE_DEC2, MODE_DEC4: keep = ch_ok && (phase[in_channel] == 2'd0);
            MODE_THR:            keep = ch_ok && (in_sample >= threshold);
            default:             keep = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ts         <= '0;
            mode_q     <= MODE_RAW;
            drop_count <= '0;
            for (int i = 0; i < N_CH; i++) phase[i] <= 2'd0;
        end else begin
            mode_q <= mode;
            if (in_valid) ts <= ts + TS_W'(1);
            if (keep && fifo_full && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            // A mode change restarts every channel's decimation phase.
            if (mode != mode_q) begin
                for (int i = 0; i < N_CH; i++) phase[i] <= 2'd0;
            end else if (ch_ok && mode == MODE_DEC2) begin
                phase[in_channel] <= {1'b0, ~phase[in_channel][0]};
            end else if (ch_ok && mode == MODE_DEC4) begin
                phase[in_channel] <= phase[in_channel] + 2'd1;
            end
        end
    end

    neural_sync_fifo #(
        .DATA_W (W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (keep),
        .wr_data ({in_channel, ts, in_sample}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    // ---- framer FSM stage ----
    assign hs = out_valid && out_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        start   = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level >= LVL_W'(FRAME_LEN)) begin
                    state_d = HDR;
                    cnt_d   = LVL_W'(FRAME_LEN);
                    start   = 1'b1;
                end else if (flush_pend && fifo_level != '0) begin
                    state_d = HDR;
                    cnt_d   = fifo_level;
                    start   = 1'b1;
                end
            end
            HDR: if (hs) state_d = PAY;
            PAY: begin
                if (hs) begin
                    pop = 1'b1;
                    if (pay_cnt == cnt - LVL_W'(1)) state_d = TRL;
                end
            end
            TRL: if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so they never follow out_ready.
    always_comb begin
        out_valid = (state != IDLE);
        out_sof   = (state == HDR);
        out_eof   = (state == TRL);
        case (state)
            HDR:     out_data = {HDR_TAG[CH_W-1:0], frame_seq, SAMPLE_W'(cnt)};
            PAY:     out_data = fifo_head;
            TRL:     out_data = chk;
            default: out_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pay_cnt    <= '0;
            chk        <= '0;
            frame_seq  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (start) begin
                pay_cnt <= '0;
                chk     <= '0;
            end else if (pop) begin
                pay_cnt <= pay_cnt + LVL_W'(1);
                chk     <= chk ^ fifo_head;
            end
            if (state == TRL && hs) frame_seq <= frame_seq + TS_W'(1);
            if (flush_req)  flush_pend <= 1'b1;
            else if (start) flush_pend <= 1'b0;
        end
    end

endmodule

// File: doc/neural_acq_framer.md
# neural_acq_framer

Single-clock acquisition framer for the implant's system-clock domain. Accepts channel-tagged ADC samples, applies timestamping, a channel-enable mask and a per-channel decimation or threshold mode, and buffers accepted samples in an internal FIFO. It emits framed words over a valid/ready stream to the telemetry path: a header word, up to FRAME_LEN payload words, then an XOR checksum trailer. It supersedes bare FIFO-to-output readout with configurable channel count, buffer depth, filtering, flush and drop accounting.

## Interface
- SAMPLE_W, 12: ADC sample width, unsigned.
- TS_W, 16: timestamp and frame sequence width.
- CH_W, 4: channel index width.
- N_CH, 16: channels present; N_CH ≤ 2^CH_W.
- DEPTH, 32: FIFO depth, power of two, ≥ FRAME_LEN.
- FRAME_LEN, 8: maximum payload words per frame; FRAME_LEN < 2^SAMPLE_W.
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample strobe; there is no backpressure.
- in_sample  in  SAMPLE_W  sample value.
- in_channel  in  CH_W  channel index.
- ch_enable  in  N_CH  per-channel accept mask.
- mode  in  2  0 raw, 1 decimate-by-2, 2 decimate-by-4, 3 threshold.
- threshold  in  SAMPLE_W  mode-3 pass level.
- flush_req  in  1  one-cycle request to emit a partial frame.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  W = CH_W+TS_W+SAMPLE_W  framed word.
- out_sof / out_eof  out  1  asserted on the header word and the trailer word, respectively.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  16  saturating count of samples lost to a full FIFO.

## Operation
- Timestamp counter (TS_W bits) increments on every in_valid, whether or not the sample is kept, and wraps. The stored word is {in_channel, timestamp pre-increment, in_sample}.
- Samples with in_channel ≥ N_CH, or with a channel disabled in ch_enable, are discarded. They are not counted in drop_count.
- Mode 1/2 keeps only these samples: each channel has a 2-bit phase counter that advances on every valid sample of that channel. A sample is kept when phase == 0; the counter wraps at 2 in mode 1 and at 4 in mode 2.
- All phase counters clear in the cycle after mode changes.
- Mode 3 keeps a sample when in_sample ≥ threshold.
- A kept sample is written when the FIFO is not full at the start of the cycle. Otherwise the sample is dropped and drop_count increments, saturating at 0xFFFF.
- A simultaneous pop does not rescue a write to a full FIFO.
- flush_req sets flush_pend. flush_pend clears when any frame starts.
- FSM states:
  - IDLE → HDR when fifo_level ≥ FRAME_LEN (cnt = FRAME_LEN), or when flush_pend and fifo_level > 0 (cnt = fifo_level). cnt is latched.
  - HDR → PAY on handshake.
  - PAY: each handshake pops one word and XORs it into chk. After cnt pops → TRL.
  - TRL → IDLE on handshake; frame_seq increments, wrapping.
- Header word is {all-ones CH_W, frame_seq, cnt zero-extended to SAMPLE_W}.
- Trailer word is the XOR of the cnt payload words.
- out_valid is high in HDR, PAY and TRL only.
- out_data, out_sof and out_eof must hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_data 0, out_sof 0, out_eof 0, fifo_level 0, drop_count 0. State IDLE; timestamp, frame_seq, phases, chk and flush_pend all 0.
- Reset asserted mid-frame aborts the frame. The FIFO contents are discarded (pointers reset) and out_valid drops asynchronously.
- Write at edge E is reflected in fifo_level after E. If that write reaches the start condition, the FSM enters HDR at E+1, so out_valid is first high in the cycle after E+1.
- With out_ready held high, one frame occupies cnt+2 consecutive cycles and IDLE lasts at least one cycle between frames.
- out_valid must not depend combinationally on out_ready. All outputs are driven from registers or from the FIFO head register.
- Simultaneous write and pop on a non-full FIFO leaves fifo_level unchanged.
- Pointers wrap modulo DEPTH.

## Structure
- Package neural_acq_pkg holds:
  - the FSM state enum (IDLE, HDR, PAY, TRL);
  - the mode constants;
  - the HDR_TAG constant;
  - a function computing W from the parameters.
- Sub-module neural_sync_fifo provides a single-clock, first-word-fall-through FIFO with level output (parameters DATA_W and DEPTH).
- The framer top contains the filter, timestamp and FSM logic.

## Test plan
- Reset, then 8 mode-0 samples on ch 3 with ready high → frame with header {0xF, 0, 8}, 8 payloads with ts 0..7, trailer equal to the XOR of the payloads; sof/eof on the first and last word.
- Mode 1, 8 samples on ch 2 and 8 on ch 5 interleaved → 8 stored words, phases 0,2,4,6 per channel; timestamps show the gaps.
- Mode 3 with threshold 0x800 and samples 0x7FF, 0x800, 0xFFF → the last two are stored.
- 3 samples, then flush_req → header count 3, 3 payloads, trailer; flush_pend clears.
- out_ready low, 40 samples written → FIFO holds 32, drop_count = 8, out_data stable while stalled; a write and pop in the same cycle on a full FIFO still drops the sample.
- Reset asserted during PAY → out_valid 0 immediately, fifo_level 0, next frame seq 0.
